// File: rtl/vedic_mul16_seq_ctrl.sv
// Sequential 16x16 -> 32 multiplier that reuses one 8x8 Vedic array over four partial-product steps.
// Define VEDIC_SIGNED_EN for two's-complement operands and product; undefined gives a purely unsigned datapath.

module vedic2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic t1, t2, t3, c1;

  assign t1   = a[1] & b[0];
  assign t2   = a[0] & b[1];
  assign t3   = a[1] & b[1];
  assign c1   = t1 & t2;
  assign p[0] = a[0] & b[0];
  assign p[1] = t1 ^ t2;
  assign p[2] = t3 ^ c1;
  assign p[3] = t3 & c1;
endmodule

module vedic4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;

  vedic2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

  assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

module vedic8x8_top (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q0, q1, q2, q3;

  vedic4x4 u_q0 (.a(a[3:0]), .b(b[3:0]), .p(q0));
  vedic4x4 u_q1 (.a(a[7:4]), .b(b[3:0]), .p(q1));
  vedic4x4 u_q2 (.a(a[3:0]), .b(b[7:4]), .p(q2));
  vedic4x4 u_q3 (.a(a[7:4]), .b(b[7:4]), .p(q3));

  assign p = {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
endmodule

module vedic_mul16_seq_ctrl #(
  parameter bit SKIP_ZERO = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_p,
  output logic             busy,
  output logic [CNT_W-1:0] perf_cnt
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state;
  logic [1:0]  step;
  logic [15:0] a_q, b_q;
  logic [31:0] acc;
  logic [7:0]  a_h, b_h;
  logic [15:0] pp;
  logic [31:0] pp_sh, acc_next, final_p;
  logic [15:0] a_mag, b_mag;
  logic        zero_in;

  // Step k selects operand bytes by k[0] (a) and k[1] (b); the array output feeds the accumulator unregistered.
  assign a_h = step[0] ? a_q[15:8] : a_q[7:0];
  assign b_h = step[1] ? b_q[15:8] : b_q[7:0];

  vedic8x8_top u_vedic (.a(a_h), .b(b_h), .p(pp));

  always_comb begin
    pp_sh = {16'b0, pp};
    case (step)
      2'd1, 2'd2: pp_sh = {8'b0, pp, 8'b0};
      2'd3:       pp_sh = {pp, 16'b0};
      default:    pp_sh = {16'b0, pp};
    endcase
  end

  assign acc_next = acc + pp_sh;
  assign zero_in  = SKIP_ZERO && ((in_a == 16'd0) || (in_b == 16'd0));

`ifdef VEDIC_SIGNED_EN
  logic sign_q;

  // |-32768| wraps to 16'h8000, which is the correct unsigned magnitude.
  assign a_mag   = in_a[15] ? (~in_a + 16'd1) : in_a;
  assign b_mag   = in_b[15] ? (~in_b + 16'd1) : in_b;
  assign final_p = sign_q ? (~acc_next + 32'd1) : acc_next;
`else
  assign a_mag   = in_a;
  assign b_mag   = in_b;
  assign final_p = acc_next;
`endif

  // NOTE: every register here is updated with non-blocking assignments so all state advances from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= 2'd0;
      a_q       <= 16'd0;
      b_q       <= 16'd0;
      acc       <= 32'd0;
      out_p     <= 32'd0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      perf_cnt  <= '0;
`ifdef VEDIC_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a_mag;
            b_q      <= b_mag;
            acc      <= 32'd0;
            step     <= 2'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef VEDIC_SIGNED_EN
            sign_q   <= in_a[15] ^ in_b[15];
`endif
            if (zero_in) begin
              // Bypass: the zero product is presented straight from the accept edge.
              state     <= DONE;
              out_p     <= 32'd0;
              out_valid <= 1'b1;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          acc  <= acc_next;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            state     <= DONE;
            out_p     <= final_p;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            if (perf_cnt != {CNT_W{1'b1}})
              perf_cnt <= perf_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vedic_mul16_seq_ctrl.sv
// Directed bench for vedic_mul16_seq_ctrl: a SKIP_ZERO=1 unit with a 16-bit counter and a SKIP_ZERO=0 unit with a 2-bit counter.
// Expected products follow VEDIC_SIGNED_EN when the bench is built with it.

module tb_vedic_mul16_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [15:0] in_a = 16'd0, in_b = 16'd0;

  logic        in_ready, out_valid, busy;
  logic [31:0] out_p;
  logic [15:0] perf_cnt;
  logic        in_ready2, out_valid2, busy2;
  logic [31:0] out_p2;
  logic [1:0]  perf_cnt2;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_cnt = 0;
  int          exp_cnt2 = 0;

  always #5 clk = ~clk;

  vedic_mul16_seq_ctrl #(.SKIP_ZERO(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy), .perf_cnt(perf_cnt)
  );

  vedic_mul16_seq_ctrl #(.SKIP_ZERO(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_p(out_p2), .busy(busy2), .perf_cnt(perf_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the selected unit: accept, measure latency, optionally stall, then hand off.
  task automatic run_op(input bit use2, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input int exp_lat, input logic [31:0] exp_p,
                        input string tag);
    int wait_n;
    int lat;
    wait_n = 0;
    while (!(use2 ? in_ready2 : in_ready) && wait_n < 20) begin
      tick();
      wait_n++;
    end
    check({tag, " ready"}, {31'd0, use2 ? in_ready2 : in_ready}, 32'd1);
    in_a = a;
    in_b = b;
    if (use2) begin in_valid2 = 1'b1; out_ready2 = (hold == 0); end
    else      begin in_valid  = 1'b1; out_ready  = (hold == 0); end
    tick();
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    in_a = ~a;
    in_b = ~b;
    check({tag, " busy"}, {31'd0, use2 ? busy2 : busy}, 32'd1);
    lat = 0;
    while (!(use2 ? out_valid2 : out_valid) && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " product"}, use2 ? out_p2 : out_p, exp_p);
    check({tag, " in_ready in DONE"}, {31'd0, use2 ? in_ready2 : in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      tick();
      check({tag, " stall valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " stall product"}, out_p, exp_p);
      check({tag, " stall in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    if (use2) out_ready2 = 1'b1;
    else      out_ready  = 1'b1;
    tick();
    if (use2) exp_cnt2 = (exp_cnt2 == 3) ? 3 : exp_cnt2 + 1;
    else      exp_cnt  = exp_cnt + 1;
    check({tag, " valid after handoff"}, {31'd0, use2 ? out_valid2 : out_valid}, 32'd0);
    check({tag, " product held"}, use2 ? out_p2 : out_p, exp_p);
    check({tag, " in_ready after handoff"}, {31'd0, use2 ? in_ready2 : in_ready}, 32'd1);
    if (use2) check({tag, " perf_cnt"}, {30'd0, perf_cnt2}, exp_cnt2);
    else      check({tag, " perf_cnt"}, {16'd0, perf_cnt}, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with in_valid asserted: nothing may be accepted while rst_n is low.
    in_valid = 1'b1;
    in_a = 16'h1111;
    in_b = 16'h2222;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    #2 rst_n = 1'b1;
    #1;
    check("release in_ready", {31'd0, in_ready}, 32'd1);
    check("release out_p", out_p, 32'd0);
    check("release perf_cnt", {16'd0, perf_cnt}, 32'd0);
    in_valid = 1'b0;
    tick();
    check("idle out_valid", {31'd0, out_valid}, 32'd0);

`ifdef VEDIC_SIGNED_EN
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 0, 4, 32'h00000001, "ffff_x_ffff");
`else
    run_op(1'b0, 16'hFFFF, 16'hFFFF, 0, 4, 32'hFFFE0001, "ffff_x_ffff");
`endif
    // 0x1234 * 0xAB = 0x000C28BC; held for 5 stalled cycles before hand-off.
    run_op(1'b0, 16'h1234, 16'h00AB, 5, 4, 32'h000C28BC, "1234_x_00ab");
    // Immediate next operation: accept may only happen once back in IDLE.
    run_op(1'b0, 16'h0100, 16'h0100, 0, 4, 32'h00010000, "0100_x_0100");

    // Zero operand: bypass on the SKIP_ZERO unit, full four steps on the other.
    run_op(1'b0, 16'h0000, 16'h5A5A, 0, 0, 32'h00000000, "skip a=0");
    run_op(1'b0, 16'h5A5A, 16'h0000, 0, 0, 32'h00000000, "skip b=0");
    run_op(1'b1, 16'h0000, 16'h5A5A, 0, 4, 32'h00000000, "noskip a=0");
    run_op(1'b1, 16'h0003, 16'h0005, 0, 4, 32'h0000000F, "noskip 3x5");
    run_op(1'b1, 16'h0010, 16'h0010, 0, 4, 32'h00000100, "noskip 10x10");
    run_op(1'b1, 16'h0002, 16'h0002, 0, 4, 32'h00000004, "noskip saturate");

    // Reset two steps into MUL: the in-flight product must never appear.
    out_ready = 1'b1;
    in_a = 16'h00FF;
    in_b = 16'h0101;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    exp_cnt2 = 0;
    check("midreset in_ready", {31'd0, in_ready}, 32'd1);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset out_p", out_p, 32'd0);
    check("midreset perf_cnt", {16'd0, perf_cnt}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midreset no valid", {31'd0, out_valid}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post reset no valid", {31'd0, out_valid}, 32'd0);
    end
    run_op(1'b0, 16'h0003, 16'h0005, 0, 4, 32'h0000000F, "3_x_5");

`ifdef VEDIC_SIGNED_EN
    run_op(1'b0, 16'hFFFE, 16'h0003, 0, 4, 32'hFFFFFFFA, "m2_x_3");
    run_op(1'b0, 16'h8000, 16'h8000, 0, 4, 32'h40000000, "min_x_min");
    run_op(1'b0, 16'h00FF, 16'hFF00, 0, 4, 32'hFFFF0100, "00ff_x_ff00");
    run_op(1'b0, 16'hFFFF, 16'h0001, 0, 4, 32'hFFFFFFFF, "ffff_x_1");
`else
    run_op(1'b0, 16'hFFFE, 16'h0003, 0, 4, 32'h0002FFFA, "fffe_x_3");
    run_op(1'b0, 16'h8000, 16'h8000, 0, 4, 32'h40000000, "8000_x_8000");
    run_op(1'b0, 16'h00FF, 16'hFF00, 0, 4, 32'h00FE0100, "00ff_x_ff00");
    run_op(1'b0, 16'hFFFF, 16'h0001, 0, 4, 32'h0000FFFF, "ffff_x_1");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
